// File: rtl/sdr_burst_responder.sv
// Toggle req/ack read port responder: one 4x16-bit SDRAM burst per request, assembled into a 64-bit line.
// Optional last-line reuse enabled by defining SDR_BURST_RESP_LINEBUF_EN.
module sdr_burst_responder #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] sdr_addr,
  input  logic                  sdr_req,
  output logic                  sdr_ack,
  output logic [63:0]           sdr_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_accept,
  input  logic                  mem_valid,
  input  logic [15:0]           mem_dq,
  output logic                  err
);

  localparam int unsigned TW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LAW = ADDR_WIDTH - 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BEAT, S_DONE} state_t;

  state_t                r_state;
  logic [3:0][15:0]      r_line;
  logic [1:0]            r_cnt;
  logic [TW-1:0]         r_tmo;
  logic                  r_tmo_evt;
  logic                  r_ack;
  logic [63:0]           r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd;
  logic                  r_err;

  logic                  w_pending;
  logic                  w_tmo_hit;
  logic [TW-1:0]         w_tmo_next;
  logic                  w_lb_hit;
  logic [63:0]           w_lb_data;

  assign w_pending  = sdr_req ^ r_ack;
  assign w_tmo_hit  = (TIMEOUT != 0) && ((32'(r_tmo) + 32'd1) >= TIMEOUT);
  // Saturating count so a disabled or very long timeout never wraps
  assign w_tmo_next = (&r_tmo) ? r_tmo : r_tmo + TW'(1);

`ifdef SDR_BURST_RESP_LINEBUF_EN
  logic           r_lb_valid;
  logic [LAW-1:0] r_lb_addr;
  logic [63:0]    r_lb_data;

  assign w_lb_hit  = r_lb_valid && (r_lb_addr == sdr_addr[ADDR_WIDTH-1:3]);
  assign w_lb_data = r_lb_data;

  // Last good line; any timed-out completion invalidates it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lb_valid <= 1'b0;
      r_lb_addr  <= '0;
      r_lb_data  <= '0;
    end else if (r_state == S_DONE) begin
      if (r_tmo_evt) begin
        r_lb_valid <= 1'b0;
      end else begin
        r_lb_valid <= 1'b1;
        r_lb_addr  <= r_addr[ADDR_WIDTH-1:3];
        r_lb_data  <= r_line;
      end
    end
  end
`else
  assign w_lb_hit  = 1'b0;
  assign w_lb_data = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_line    <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_tmo_evt <= 1'b0;
      r_ack     <= 1'b0;
      r_data    <= '0;
      r_addr    <= '0;
      r_rd      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pending) begin
            r_tmo_evt <= 1'b0;
            if (w_lb_hit) begin
              r_line  <= w_lb_data;
              r_state <= S_DONE;
            end else begin
              r_addr  <= {sdr_addr[ADDR_WIDTH-1:3], 3'b000};
              r_rd    <= 1'b1;
              r_line  <= '0;
              r_tmo   <= '0;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_tmo <= mem_valid ? '0 : w_tmo_next;
          if (mem_accept) begin
            r_rd    <= 1'b0;
            r_state <= S_BEAT;
            if (mem_valid) begin
              r_line[0] <= mem_dq;
              r_cnt     <= 2'd1;
            end else begin
              r_cnt     <= 2'd0;
            end
          end
          if (!mem_valid && w_tmo_hit) begin
            r_rd      <= 1'b0;
            r_err     <= 1'b1;
            r_tmo_evt <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_BEAT: begin
          if (mem_valid) begin
            r_line[r_cnt] <= mem_dq;
            r_cnt         <= r_cnt + 2'd1;
            r_tmo         <= '0;
            if (r_cnt == 2'd3) r_state <= S_DONE;
          end else if (w_tmo_hit) begin
            r_err     <= 1'b1;
            r_tmo_evt <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_tmo <= w_tmo_next;
          end
        end
        S_DONE: begin
          r_data  <= r_line;
          r_ack   <= ~r_ack;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sdr_ack  = r_ack;
  assign sdr_data = r_data;
  assign mem_addr = r_addr;
  assign mem_rd   = r_rd;
  assign err      = r_err;

endmodule

// File: tb/tb_sdr_burst_responder.sv
// Scoreboard bench for sdr_burst_responder: directed requests push expected burst addresses and lines,
// a negedge monitor pops and compares on every mem_rd rise and every sdr_ack toggle.
module tb_sdr_burst_responder;

  localparam int unsigned AW = 27;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] sdr_addr;
  logic          sdr_req;
  logic          sdr_ack;
  logic [63:0]   sdr_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_accept;
  logic          mem_valid;
  logic [15:0]   mem_dq;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] exp_addr[$];
  logic [64:0]   exp_line[$];

  logic prev_rd  = 1'b0;
  logic prev_ack = 1'b0;

  sdr_burst_responder #(.ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sdr_addr   (sdr_addr),
    .sdr_req    (sdr_req),
    .sdr_ack    (sdr_ack),
    .sdr_data   (sdr_data),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_accept (mem_accept),
    .mem_valid  (mem_valid),
    .mem_dq     (mem_dq),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [64:0] e;
    if (reset_n) begin
      if (mem_rd && !prev_rd) begin
        if (exp_addr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_mem_rd: got addr %h expected no burst", mem_addr);
        end else begin
          chk("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
        end
      end
      if (sdr_ack !== prev_ack) begin
        if (exp_line.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: got data %h expected no completion", sdr_data);
        end else begin
          e = exp_line.pop_front();
          chk("sdr_data", sdr_data, e[63:0]);
          chk1("err_at_ack", err, e[64]);
        end
      end
    end
    prev_rd  = mem_rd;
    prev_ack = sdr_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input int gap);
    repeat (gap) tick();
    mem_valid = 1'b1;
    mem_dq    = d;
    tick();
    mem_valid = 1'b0;
    mem_dq    = '0;
  endtask

  task automatic accept(input int wait_cyc, input logic with_beat, input logic [15:0] d);
    repeat (wait_cyc) tick();
    mem_accept = 1'b1;
    mem_valid  = with_beat;
    mem_dq     = d;
    tick();
    mem_accept = 1'b0;
    mem_valid  = 1'b0;
    mem_dq     = '0;
  endtask

  task automatic wait_ack(input logic want, output int n);
    n = 0;
    while (sdr_ack !== want && n < 32) begin
      tick();
      n++;
    end
  endtask

  task automatic request(input logic [AW-1:0] a, input logic r);
    sdr_addr = a;
    sdr_req  = r;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n    = 1'b0;
    sdr_addr   = '0;
    sdr_req    = 1'b0;
    mem_accept = 1'b0;
    mem_valid  = 1'b0;
    mem_dq     = '0;
    #12;
    chk1("rst_ack", sdr_ack, 1'b0);
    chk("rst_data", sdr_data, 64'd0);
    chk1("rst_rd", mem_rd, 1'b0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk1("rst_err", err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Basic fetch
    exp_addr.push_back(27'h0100008);
    exp_line.push_back({1'b0, 64'h4444_3333_2222_1111});
    request(27'h010000A, 1'b1);
    chk1("basic_rd_high", mem_rd, 1'b1);
    tick();
    chk1("basic_rd_held", mem_rd, 1'b1);
    accept(1, 1'b0, '0);
    chk1("basic_rd_low", mem_rd, 1'b0);
    beat(16'h1111, 0);
    beat(16'h2222, 0);
    beat(16'h3333, 0);
    beat(16'h4444, 0);
    chk1("basic_ack_not_yet", sdr_ack, 1'b0);
    tick();
    chk1("basic_ack", sdr_ack, 1'b1);

    // Gapped beats with stray beats in IDLE
    beat(16'hDEAD, 0);
    beat(16'hBEEF, 2);
    chk1("stray_ack", sdr_ack, 1'b1);
    chk1("stray_rd", mem_rd, 1'b0);
    exp_addr.push_back(27'h2000010);
    exp_line.push_back({1'b0, 64'h8888_7777_6666_5555});
    request(27'h2000013, 1'b0);
    chk1("gap_rd_high", mem_rd, 1'b1);
    accept(1, 1'b0, '0);
    beat(16'h5555, 0);
    beat(16'h6666, 0);
    beat(16'h7777, 3);
    chk("gap_data_hold", sdr_data, 64'h4444_3333_2222_1111);
    beat(16'h8888, 1);
    chk1("gap_ack_not_yet", sdr_ack, 1'b1);
    tick();
    chk1("gap_ack", sdr_ack, 1'b0);

    // Back-to-back, beat0 in the accept cycle
    exp_addr.push_back(27'h0000040);
    exp_line.push_back({1'b0, 64'h0D0D_0C0C_0B0B_0A0A});
    request(27'h0000040, 1'b1);
    chk1("b2b_rd_high", mem_rd, 1'b1);
    chk("b2b_data_hold", sdr_data, 64'h8888_7777_6666_5555);
    accept(0, 1'b1, 16'h0A0A);
    beat(16'h0B0B, 0);
    beat(16'h0C0C, 0);
    chk("b2b_data_hold2", sdr_data, 64'h8888_7777_6666_5555);
    beat(16'h0D0D, 0);
    tick();
    chk1("b2b_ack", sdr_ack, 1'b1);

    // Timeout after two beats
    exp_addr.push_back(27'h3000000);
    exp_line.push_back({1'b1, 64'h0000_0000_BBBB_AAAA});
    request(27'h3000004, 1'b0);
    accept(1, 1'b0, '0);
    beat(16'hAAAA, 0);
    beat(16'hBBBB, 0);
    chk1("tmo_err_early", err, 1'b0);
    wait_ack(1'b0, n);
    chk("tmo_latency", 64'(n), 64'd9);
    chk1("tmo_err", err, 1'b1);
    repeat (5) tick();
    chk1("tmo_err_sticky", err, 1'b1);

    // Reset in the middle of a burst
    exp_addr.push_back(27'h0000500);
    request(27'h0000500, 1'b1);
    accept(0, 1'b1, 16'h9999);
    beat(16'h9998, 0);
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_ack", sdr_ack, 1'b0);
    chk("mid_rst_data", sdr_data, 64'd0);
    chk1("mid_rst_rd", mem_rd, 1'b0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk1("mid_rst_err", err, 1'b0);
    @(negedge clk);
    exp_addr.push_back(27'h0000500);
    exp_line.push_back({1'b0, 64'h1004_1003_1002_1001});
    reset_n = 1'b1;
    tick();
    chk1("post_rst_rd", mem_rd, 1'b1);
    accept(0, 1'b1, 16'h1001);
    beat(16'h1002, 0);
    beat(16'h1003, 1);
    beat(16'h1004, 0);
    wait_ack(1'b1, n);
    chk1("post_rst_ack", sdr_ack, 1'b1);

`ifdef SDR_BURST_RESP_LINEBUF_EN
    // Same line again: served from the last-line register
    exp_line.push_back({1'b0, 64'h1004_1003_1002_1001});
    request(27'h0000503, 1'b0);
    chk1("lb_rd_low", mem_rd, 1'b0);
    chk1("lb_ack_not_yet", sdr_ack, 1'b1);
    tick();
    chk1("lb_ack", sdr_ack, 1'b0);
    chk1("lb_rd_low2", mem_rd, 1'b0);

    // A timeout invalidates the stored line
    exp_addr.push_back(27'h0000600);
    exp_line.push_back({1'b1, 64'h0000_0000_0000_CCCC});
    request(27'h0000600, 1'b1);
    accept(0, 1'b1, 16'hCCCC);
    wait_ack(1'b1, n);
    chk1("lb_tmo_ack", sdr_ack, 1'b1);
    exp_addr.push_back(27'h0000500);
    exp_line.push_back({1'b1, 64'h2004_2003_2002_2001});
    request(27'h0000500, 1'b0);
    chk1("lb_reissue_rd", mem_rd, 1'b1);
    accept(0, 1'b1, 16'h2001);
    beat(16'h2002, 0);
    beat(16'h2003, 0);
    beat(16'h2004, 0);
    wait_ack(1'b0, n);
    chk1("lb_reissue_ack", sdr_ack, 1'b0);
`endif

    repeat (3) tick();
    chk("addr_queue_empty", 64'(exp_addr.size()), 64'd0);
    chk("line_queue_empty", 64'(exp_line.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
